cdic_regs: RTL and testbench

- CD-interface controller (CDIC) slave on the SCC68070 16-bit bus, decoded at 0x300000–0x30FFFF.
- Contains:
  - a word-addressed sector buffer RAM;
  - the CDIC command/status register set: command, time, file, channel, audio channel, ABUF, XBUF, DMA control, interrupt vector, data buffer.
- Reads are combinational; writes complete in zero wait states with byte-lane enables. The block never stalls the bus.

---
 rtl/cdic_regs.sv | 168 ++++++++++++++++
 tb/tb_cdic_regs.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cdic_regs.sv
// CD-interface controller (CDIC) slave: sector buffer RAM plus command/status registers.
// Reads are combinational, writes land on the rising clk edge with zero wait states.
// Never stalls the bus; there is no ready/wait output.
//
// Ports:
//   clk, reset_n      : system clock, asynchronous active-low reset
//   address[23:1]     : CPU word address; only [13:1] decoded (registers mirror over 64 KB)
//   din / dout        : write data / combinational read data (0x0000 when cs=0)
//   uds / lds         : upper / lower byte strobes, active high
//   write_strobe, cs  : 1 = write cycle; chip select, active high
//
// Optional feature: define CDIC_SECTOR_RAM_EN to build the RAM_WORDS x 16 sector
// buffer at 0x0000-0x3BFF. Without it that range reads 0x0000 and ignores writes.
module cdic_regs #(
  parameter int RAM_WORDS = 7680
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:1] address,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic        cs
);

  localparam logic [13:0] OFF_CMD     = 14'h3C00;
  localparam logic [13:0] OFF_TIME_HI = 14'h3C02;
  localparam logic [13:0] OFF_TIME_LO = 14'h3C04;
  localparam logic [13:0] OFF_FILE    = 14'h3C06;
  localparam logic [13:0] OFF_CHAN_HI = 14'h3C08;
  localparam logic [13:0] OFF_CHAN_LO = 14'h3C0A;
  localparam logic [13:0] OFF_ACHAN   = 14'h3C0C;
  localparam logic [13:0] OFF_ABUF    = 14'h3FF4;
  localparam logic [13:0] OFF_XBUF    = 14'h3FF6;
  localparam logic [13:0] OFF_DMACTL  = 14'h3FF8;
  localparam logic [13:0] OFF_AUDCTL  = 14'h3FFA;
  localparam logic [13:0] OFF_IVEC    = 14'h3FFC;
  localparam logic [13:0] OFF_DBUF    = 14'h3FFE;
  localparam logic [12:0] RAM_LIMIT   = 13'(RAM_WORDS);

  logic        access, wr, rd;
  logic [13:0] off;
  logic        in_ram;
  logic        trig_d;

  logic [15:0] cmd_q, time_hi_q, time_lo_q, file_q, chan_hi_q, chan_lo_q, achan_q;
  logic [15:0] abuf_q, xbuf_q, dmactl_q, audctl_q, ivec_q, dbuf_q;
  logic        abuf_pend_q, xbuf_pend_q, trig_q;
  logic [15:0] ram_rdata;

  // Bits [23:14] are intentionally ignored so the window mirrors.
  logic unused_addr;
  assign unused_addr = ^address[23:14];

  assign access = cs && (uds || lds);
  assign wr     = access && write_strobe;
  assign rd     = access && !write_strobe;
  assign off    = {address[13:1], 1'b0};
  assign in_ram = (address[13:1] < RAM_LIMIT);

  // DBUF bit 15 written through the upper lane requests a command completion.
  assign trig_d = wr && uds && (off == OFF_DBUF) && din[15];

  function automatic logic [15:0] merge(input logic [15:0] old);
    merge = {uds ? din[15:8] : old[15:8], lds ? din[7:0] : old[7:0]};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q       <= 16'h0000;
      time_hi_q   <= 16'h0000;
      time_lo_q   <= 16'h0000;
      file_q      <= 16'h0000;
      chan_hi_q   <= 16'h0000;
      chan_lo_q   <= 16'h0000;
      achan_q     <= 16'h0000;
      abuf_q      <= 16'h0000;
      xbuf_q      <= 16'h0000;
      dmactl_q    <= 16'h0000;
      audctl_q    <= 16'h0000;
      ivec_q      <= 16'h000F;
      dbuf_q      <= 16'h0000;
      abuf_pend_q <= 1'b0;
      xbuf_pend_q <= 1'b0;
      trig_q      <= 1'b0;
    end else begin
      // Read-clear waits for the bus to go idle so dout holds for the whole access.
      if (rd && off == OFF_ABUF) abuf_pend_q <= 1'b1;
      else if (!access)          abuf_pend_q <= 1'b0;
      if (rd && off == OFF_XBUF) xbuf_pend_q <= 1'b1;
      else if (!access)          xbuf_pend_q <= 1'b0;

      if (abuf_pend_q && !access) abuf_q[15] <= 1'b0;
      if (xbuf_pend_q && !access) xbuf_q[15] <= 1'b0;

      // Command completion one cycle after the trigger write; placed after the
      // read-clear so the set wins if both land on the same edge.
      trig_q <= trig_d;
      if (trig_q) begin
        dbuf_q[15] <= 1'b0;
        xbuf_q     <= {1'b1, cmd_q[14:0]};
      end

      // ABUF/XBUF are status-only and have no write case.
      if (wr) begin
        unique case (off)
          OFF_CMD:     cmd_q     <= merge(cmd_q);
          OFF_TIME_HI: time_hi_q <= merge(time_hi_q);
          OFF_TIME_LO: time_lo_q <= merge(time_lo_q);
          OFF_FILE:    file_q    <= merge(file_q);
          OFF_CHAN_HI: chan_hi_q <= merge(chan_hi_q);
          OFF_CHAN_LO: chan_lo_q <= merge(chan_lo_q);
          OFF_ACHAN:   achan_q   <= merge(achan_q);
          OFF_DMACTL:  dmactl_q  <= merge(dmactl_q);
          OFF_AUDCTL:  audctl_q  <= merge(audctl_q);
          OFF_IVEC:    ivec_q    <= merge(ivec_q);
          OFF_DBUF:    dbuf_q    <= merge(dbuf_q);
          default: ;
        endcase
      end
    end
  end

`ifdef CDIC_SECTOR_RAM_EN
  logic [15:0] ram [RAM_WORDS];

  // Sector data is not reset.
  always_ff @(posedge clk) begin
    if (wr && in_ram) begin
      if (uds) ram[address[13:1]][15:8] <= din[15:8];
      if (lds) ram[address[13:1]][7:0]  <= din[7:0];
    end
  end

  assign ram_rdata = in_ram ? ram[address[13:1]] : 16'h0000;
`else
  assign ram_rdata = 16'h0000;
`endif

  always_comb begin
    dout = 16'h0000;
    if (cs) begin
      if (in_ram) begin
        dout = ram_rdata;
      end else begin
        unique case (off)
          OFF_CMD:     dout = cmd_q;
          OFF_TIME_HI: dout = time_hi_q;
          OFF_TIME_LO: dout = time_lo_q;
          OFF_FILE:    dout = file_q;
          OFF_CHAN_HI: dout = chan_hi_q;
          OFF_CHAN_LO: dout = chan_lo_q;
          OFF_ACHAN:   dout = achan_q;
          OFF_ABUF:    dout = abuf_q;
          OFF_XBUF:    dout = xbuf_q;
          OFF_DMACTL:  dout = dmactl_q;
          OFF_AUDCTL:  dout = audctl_q;
          OFF_IVEC:    dout = ivec_q;
          OFF_DBUF:    dout = dbuf_q;
          default:     dout = 16'h0000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdic_regs.sv
module tb_cdic_regs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:1] address;
  logic [15:0] din;
  logic [15:0] dout;
  logic        uds, lds, write_strobe, cs;

  int n_checks = 0;
  int n_errors = 0;

  cdic_regs dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .din          (din),
    .dout         (dout),
    .uds          (uds),
    .lds          (lds),
    .write_strobe (write_strobe),
    .cs           (cs)
  );

  always #5 clk = ~clk;

  function automatic logic [23:1] waddr(input logic [23:0] byte_addr);
    waddr = byte_addr[23:1];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cs = 1'b0; write_strobe = 1'b0; uds = 1'b0; lds = 1'b0;
  endtask

  // One write cycle, set up on the falling edge, committed on the next rising edge.
  task automatic wr(input logic [23:0] a, input logic [15:0] d, input logic u, input logic l);
    @(negedge clk);
    address = waddr(a); din = d; uds = u; lds = l; write_strobe = 1'b1; cs = 1'b1;
    @(posedge clk);
    #1 idle();
  endtask

  // Read that spans one rising edge (arms read-clear flags).
  task automatic rd(input string tag, input logic [23:0] a, input logic [15:0] exp);
    @(negedge clk);
    address = waddr(a); uds = 1'b1; lds = 1'b1; write_strobe = 1'b0; cs = 1'b1;
    #1 check(tag, dout, exp);
    @(posedge clk);
    #1 idle();
  endtask

  // Read that ends before the next rising edge (no side effects).
  task automatic peek(input string tag, input logic [23:0] a, input logic [15:0] exp);
    @(negedge clk);
    address = waddr(a); uds = 1'b1; lds = 1'b1; write_strobe = 1'b0; cs = 1'b1;
    #1 check(tag, dout, exp);
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    address = '0; din = '0;
    idle();
    #12 check("reset_dout_cs0", dout, 16'h0000);
    @(negedge clk) reset_n = 1'b1;

    // Reset values
    rd("rst_ivec", 24'h303FFC, 16'h000F);
    rd("rst_cmd",  24'h303C00, 16'h0000);
    rd("rst_xbuf", 24'h303FF6, 16'h0000);

    // Byte lanes
    wr(24'h303C06, 16'hABCD, 1'b1, 1'b0);
    rd("file_uds", 24'h303C06, 16'hAB00);
    wr(24'h303C06, 16'h1234, 1'b0, 1'b1);
    rd("file_lds", 24'h303C06, 16'hAB34);
    rd("file_mirror", 24'h313C06, 16'hAB34);

    // Command trigger
    wr(24'h303C00, 16'h0023, 1'b1, 1'b1);
    wr(24'h303FFE, 16'h8000, 1'b1, 1'b1);
    peek("xbuf_pre_trig", 24'h303FF6, 16'h0000);
    peek("dbuf_cleared",  24'h303FFE, 16'h0000);
    peek("xbuf_done",     24'h303FF6, 16'h8023);

    // Held XBUF read keeps dout stable, then clears bit 15 once idle
    @(negedge clk);
    address = waddr(24'h303FF6); uds = 1'b1; lds = 1'b1; write_strobe = 1'b0; cs = 1'b1;
    #1 check("xbuf_hold0", dout, 16'h8023);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("xbuf_hold%0d", i), dout, 16'h8023);
    end
    idle();
    peek("xbuf_readclr", 24'h303FF6, 16'h0023);

    // Strobes do not gate dout; cs does
    @(negedge clk);
    address = waddr(24'h303FFC); uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; cs = 1'b1;
    #1 check("no_strobe_read", dout, 16'h000F);
    cs = 1'b0; uds = 1'b1; lds = 1'b1;
    #1 check("cs0_read", dout, 16'h0000);
    idle();

    // Trigger needs uds: lower-lane-only write with din[15]=1 must not fire
    wr(24'h303FFE, 16'h8001, 1'b0, 1'b1);
    rd("dbuf_lds_only", 24'h303FFE, 16'h0001);
    peek("xbuf_no_trig", 24'h303FF6, 16'h0023);

    // Status registers are write-protected
    wr(24'h303FF4, 16'hFFFF, 1'b1, 1'b1);
    rd("abuf_wprot", 24'h303FF4, 16'h0000);
    wr(24'h303FF6, 16'hFFFF, 1'b1, 1'b1);
    peek("xbuf_wprot", 24'h303FF6, 16'h0023);

    // Other registers and unmapped space
    wr(24'h303C02, 16'h1111, 1'b1, 1'b1);
    wr(24'h303FF8, 16'hBEEF, 1'b1, 1'b1);
    wr(24'h303C0C, 16'h00C3, 1'b1, 1'b1);
    rd("time_hi", 24'h303C02, 16'h1111);
    rd("dmactl",  24'h303FF8, 16'hBEEF);
    rd("achan",   24'h303C0C, 16'h00C3);
    wr(24'h303D00, 16'hFFFF, 1'b1, 1'b1);
    rd("unmapped_3d00", 24'h303D00, 16'h0000);
    rd("unmapped_3c0e", 24'h303C0E, 16'h0000);

    // Sector RAM range
    wr(24'h300010, 16'h5A5A, 1'b1, 1'b1);
    wr(24'h303BFE, 16'hA5A5, 1'b1, 1'b1);
`ifdef CDIC_SECTOR_RAM_EN
    rd("ram_0010",  24'h300010, 16'h5A5A);
    rd("ram_3bfe",  24'h303BFE, 16'hA5A5);
    rd("ram_alias", 24'h310010, 16'h5A5A);
    wr(24'h300010, 16'h00FF, 1'b0, 1'b1);
    rd("ram_lane",  24'h300010, 16'h5AFF);
`else
    rd("ram_off_0010", 24'h300010, 16'h0000);
    rd("ram_off_3bfe", 24'h303BFE, 16'h0000);
`endif

    // Asynchronous reset between trigger write and completion edge
    wr(24'h303C00, 16'h0055, 1'b1, 1'b1);
    wr(24'h303FFE, 16'h8000, 1'b1, 1'b1);
    #1 reset_n = 1'b0;
    #1 check("rst_async_ivec_cs0", dout, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    peek("rst_mid_xbuf", 24'h303FF6, 16'h0000);
    peek("rst_mid_dbuf", 24'h303FFE, 16'h0000);
    peek("rst_mid_ivec", 24'h303FFC, 16'h000F);
    peek("rst_mid_cmd",  24'h303C00, 16'h0000);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
